// File: rtl/seq_sop_mac.sv
// Sequential sum-of-products MAC: two shift-and-add multiplies (a*b, then c*d),
// summed into a load/accumulate result register with sticky overflow and a hex display.
module seq_sop_mac #(
   parameter int W     = 4,
   parameter int ACC_W = 2 * W + 4,
   parameter int ND    = (ACC_W + 3) / 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              acc_mode,
   input  logic              clr,
   input  logic [W-1:0]      a,
   input  logic [W-1:0]      b,
   input  logic [W-1:0]      c,
   input  logic [W-1:0]      d,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result,
   output logic              ovf,
   output logic [8*ND-1:0]   hex_out
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MAB  = 2'd1;
   localparam logic [1:0] MCD  = 2'd2;
   localparam logic [1:0] SUM  = 2'd3;

   logic [1:0]       state_r;
   logic [CW-1:0]    cnt_r;
   logic [2*W-1:0]   mcand_r;
   logic [W-1:0]     mplier_r;
   logic [W-1:0]     c_r;
   logic [W-1:0]     d_r;
   logic             mode_r;
   logic [2*W-1:0]   pab_r;
   logic [2*W-1:0]   pcd_r;
   logic [ACC_W-1:0] result_r;
   logic             ovf_r;
   logic             busy_r;
   logic             done_r;

   logic             accept_s;
   logic             last_s;
   logic [2*W-1:0]   addend_s;
   logic [2*W:0]     sum_s;
   logic [ACC_W:0]   acc_sum_s;
   logic [4*ND-1:0]  res_pad_s;

   function automatic logic [7:0] seg7(input logic [3:0] nib);
      logic [7:0] code;
      case (nib)
         4'h0: code = 8'hC0;
         4'h1: code = 8'hF9;
         4'h2: code = 8'hA4;
         4'h3: code = 8'hB0;
         4'h4: code = 8'h99;
         4'h5: code = 8'h92;
         4'h6: code = 8'h82;
         4'h7: code = 8'hF8;
         4'h8: code = 8'h80;
         4'h9: code = 8'h90;
         4'hA: code = 8'h88;
         4'hB: code = 8'h83;
         4'hC: code = 8'hC6;
         4'hD: code = 8'hA1;
         4'hE: code = 8'h86;
         4'hF: code = 8'h8E;
         default: code = 8'hFF;
      endcase
      return code;
   endfunction

   // Clear takes effect before capture, so clr+start accumulates onto zero.
   assign accept_s  = (state_r == IDLE) && start;
   assign last_s    = (cnt_r == CW'(W - 1));
   assign addend_s  = mplier_r[0] ? mcand_r : {(2*W){1'b0}};
   assign sum_s     = {1'b0, pab_r} + {1'b0, pcd_r};
   assign acc_sum_s = {1'b0, result_r} + (ACC_W + 1)'(sum_s);
   assign res_pad_s = (4*ND)'(result_r);

   // Control FSM and shift-and-add datapath.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
         c_r      <= '0;
         d_r      <= '0;
         mode_r   <= 1'b0;
         pab_r    <= '0;
         pcd_r    <= '0;
         result_r <= '0;
         ovf_r    <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (clr) begin
                  result_r <= '0;
                  ovf_r    <= 1'b0;
               end
               if (accept_s) begin
                  mcand_r  <= {{W{1'b0}}, a};
                  mplier_r <= b;
                  c_r      <= c;
                  d_r      <= d;
                  mode_r   <= acc_mode;
                  pab_r    <= '0;
                  pcd_r    <= '0;
                  cnt_r    <= '0;
                  busy_r   <= 1'b1;
                  state_r  <= MAB;
               end else begin
                  busy_r   <= 1'b0;
               end
            end
            MAB: begin
               pab_r <= pab_r + addend_s;
               if (last_s) begin
                  mcand_r  <= {{W{1'b0}}, c_r};
                  mplier_r <= d_r;
                  cnt_r    <= '0;
                  state_r  <= MCD;
               end else begin
                  mcand_r  <= mcand_r << 1;
                  mplier_r <= mplier_r >> 1;
                  cnt_r    <= cnt_r + CW'(1);
               end
            end
            MCD: begin
               pcd_r    <= pcd_r + addend_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               if (last_s) begin
                  cnt_r   <= '0;
                  state_r <= SUM;
               end else begin
                  cnt_r   <= cnt_r + CW'(1);
               end
            end
            SUM: begin
               if (mode_r) begin
                  result_r <= acc_sum_s[ACC_W-1:0];
                  ovf_r    <= ovf_r | acc_sum_s[ACC_W];
               end else begin
                  result_r <= ACC_W'(sum_s);
               end
               done_r  <= 1'b1;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

   // Seven-segment decode of each result nibble, decimal point off.
   always_comb begin
      hex_out = {(8*ND){1'b1}};
      for (int i = 0; i < ND; i++) begin
         hex_out[8*i +: 8] = seg7(res_pad_s[4*i +: 4]);
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;
   assign ovf    = ovf_r;

endmodule

// File: tb/tb_seq_sop_mac.sv
// Directed bench for seq_sop_mac: scoreboard of expected results checked on each
// done pulse, plus cycle-exact busy/done/result/ovf/hex checks per operation.
module tb_seq_sop_mac;

   localparam int W     = 4;
   localparam int ACC_W = 12;
   localparam int ND    = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic             acc_mode;
   logic             clr;
   logic [W-1:0]     a;
   logic [W-1:0]     b;
   logic [W-1:0]     c;
   logic [W-1:0]     d;
   logic             busy;
   logic             done;
   logic [ACC_W-1:0] result;
   logic             ovf;
   logic [8*ND-1:0]  hex_out;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int last_done_cyc = -1;
   int done_gap = 0;
   logic [ACC_W-1:0] exp_q[$];
   logic [ACC_W-1:0] m_acc = '0;
   logic             m_ovf = 1'b0;

   seq_sop_mac #(.W(W), .ACC_W(ACC_W), .ND(ND)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .acc_mode(acc_mode), .clr(clr),
      .a(a), .b(b), .c(c), .d(d),
      .busy(busy), .done(done), .result(result), .ovf(ovf), .hex_out(hex_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] hex_model(input logic [11:0] v);
      logic [7:0]  tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
      logic [23:0] h;
      for (int i = 0; i < 3; i++) h[8*i +: 8] = tbl[v[4*i +: 4]];
      return h;
   endfunction

   // Scoreboard: every done pulse pops one expected result.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && done === 1'b1) begin
         check("sb_nonempty_at_done", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("sb_result", 32'(result), 32'(exp_q.pop_front()));
         if (last_done_cyc >= 0) done_gap = cyc - last_done_cyc;
         last_done_cyc = cyc;
         done_cnt++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic [3:0] ia, input logic [3:0] ib, input logic [3:0] ic,
                     input logic [3:0] id, input logic mode, input logic with_clr,
                     input logic clr_mid, input string tag);
      logic [8:0]  s;
      logic [12:0] t;
      a = ia; b = ib; c = ic; d = id; acc_mode = mode; start = 1'b1; clr = with_clr;
      if (with_clr) begin
         m_acc = '0;
         m_ovf = 1'b0;
      end
      s = 9'(ia) * 9'(ib) + 9'(ic) * 9'(id);
      if (mode) begin
         t = {1'b0, m_acc} + 13'(s);
         m_acc = t[11:0];
         m_ovf = m_ovf | t[12];
      end else begin
         m_acc = 12'(s);
      end
      exp_q.push_back(m_acc);
      step();
      start = 1'b0;
      clr   = 1'b0;
      for (int i = 1; i <= 2*W + 1; i++) begin
         if (i == 3) begin
            a = ~ia; b = ~ib; c = ~ic; d = ~id; acc_mode = ~mode;
            clr = clr_mid;
         end else begin
            clr = 1'b0;
         end
         step();
         check({tag, "_busy"}, 32'(busy), 32'd1);
         check({tag, "_done"}, 32'(done), 32'(i == 2*W + 1));
      end
      clr = 1'b0;
      check({tag, "_result"}, 32'(result), 32'(m_acc));
      check({tag, "_ovf"}, 32'(ovf), 32'(m_ovf));
      check({tag, "_hex"}, 32'(hex_out), 32'(hex_model(m_acc)));
      step();
      check({tag, "_done_low"}, 32'(done), 32'd0);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int base;
      rst_n = 1'b0; start = 1'b0; acc_mode = 1'b0; clr = 1'b0;
      a = '0; b = '0; c = '0; d = '0;
      repeat (3) step();
      rst_n = 1'b1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      check("rst_hex", 32'(hex_out), 32'hC0C0C0);

      op(4'd3, 4'd5, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0, "load");
      check("load_val", 32'(result), 32'h01D);
      check("load_hexval", 32'(hex_out), 32'hC0F9A1);
      op(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0, "accum");
      check("accum_val", 32'(result), 32'h1DF);
      check("accum_hexval", 32'(hex_out), 32'hF9A18E);

      clr = 1'b1;
      step();
      clr = 1'b0;
      m_acc = '0; m_ovf = 1'b0;
      check("clr_result", 32'(result), 32'd0);
      check("clr_ovf", 32'(ovf), 32'd0);

      for (int n = 0; n < 10; n++) op(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 1'b0, (n == 4), "ovfrun");
      check("ovf_val", 32'(result), 32'h194);
      check("ovf_set", 32'(ovf), 32'd1);
      op(4'd15, 4'd15, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, "load_keeps_ovf");
      check("ovf_held", 32'(ovf), 32'd1);

      base = done_cnt;
      a = 4'd3; b = 4'd5; c = 4'd2; d = 4'd7; acc_mode = 1'b0; start = 1'b1;
      exp_q.push_back(12'd29);
      exp_q.push_back(12'd17);
      for (int j = 0; j < 20; j++) begin
         if (j == 3) begin
            a = 4'd4; b = 4'd4; c = 4'd1; d = 4'd1;
         end
         step();
      end
      start = 1'b0;
      m_acc = 12'd17;
      repeat (4) step();
      check("hold_done_count", 32'(done_cnt - base), 32'd2);
      check("hold_done_gap", 32'(done_gap), 32'd10);
      check("hold_result", 32'(result), 32'd17);

      a = 4'd15; b = 4'd15; c = 4'd15; d = 4'd15; acc_mode = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      repeat (4) step();
      rst_n = 1'b0;
      step();
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", 32'(result), 32'd0);
      check("midrst_ovf", 32'(ovf), 32'd0);
      check("midrst_hex", 32'(hex_out), 32'hC0C0C0);
      rst_n = 1'b1;
      m_acc = '0; m_ovf = 1'b0;
      base = done_cnt;
      repeat (10) step();
      check("midrst_no_done", 32'(done_cnt - base), 32'd0);
      op(4'd3, 4'd5, 4'd2, 4'd7, 1'b0, 1'b0, 1'b0, "after_rst");
      op(4'd15, 4'd15, 4'd15, 4'd15, 1'b1, 1'b0, 1'b0, "pre_clrstart");
      check("pre_clrstart_val", 32'(result), 32'h1DF);
      op(4'd1, 4'd1, 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, "clrstart");
      check("clrstart_val", 32'(result), 32'h001);
      check("clrstart_ovf", 32'(ovf), 32'd0);

      repeat (2) step();
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/seq_sop_mac.md
SEQ_SOP_MAC -- requirements
Module: seq_sop_mac

Interface
REQ-001 Parameter: W, default 4, operand width in bits (W >= 2).
REQ-002 Parameter: ACC_W, default 2*W+4, accumulator/result width (ACC_W >= 2*W+1).
REQ-003 Parameter: ND, default ceil(ACC_W/4), number of seven-segment digits driven.
REQ-004 Clock and reset SHALL be one clock and a synchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, synchronous active-low reset.
REQ-005 Port: start, input, 1 bit; request one sum-of-products operation.
REQ-006 Port: acc_mode, input, 1 bit; 0 = load (result = a*b + c*d), 1 = accumulate (result += a*b + c*d).
REQ-007 Port: clr, input, 1 bit; clear result and overflow flag.
REQ-008 Ports: a, b, c, d, input, W bits each; unsigned operands.
REQ-009 Port: busy, output, 1 bit; operation in progress.
REQ-010 Port: done, output, 1 bit; single-cycle completion pulse.
REQ-011 Port: result, output, ACC_W bits; registered result.
REQ-012 Port: ovf, output, 1 bit; sticky accumulate-overflow flag.
REQ-013 Port: hex_out, output, 8*ND bits; active-low seven-segment codes, digit i in bits [8i+7:8i], digit 0 = least significant nibble.

Function
REQ-014 FSM states SHALL be IDLE, MAB, MCD and SUM.
- IDLE -> MAB: on start=1.
- MAB -> MCD: after exactly W cycles.
- MCD -> SUM: after exactly W cycles.
- SUM -> IDLE: after 1 cycle.
REQ-015 On the accepting edge, a, b, c, d and acc_mode SHALL be captured; later input changes SHALL NOT affect the operation.
REQ-016 MAB SHALL compute a*b by shift-and-add, one multiplier bit per cycle, LSB first, into a 2W-bit product register.
REQ-017 MCD SHALL compute c*d the same way.
REQ-018 SUM SHALL form the (2W+1)-bit sum a*b + c*d (no truncation) and write result:
- zero-extended sum if captured mode = 0;
- result + sum, modulo 2^ACC_W, if captured mode = 1.
REQ-019 Latency: with start accepted at edge k, result SHALL update and done SHALL be 1 after edge k+2W+1; done SHALL be 0 after edge k+2W+2.
REQ-020 busy SHALL be 1 after edges k+1 through k+2W+1 and 0 in IDLE; busy and done SHALL be high together in the completion cycle.
REQ-021 start while busy=1 SHALL be ignored (no queueing); start on the completion-cycle edge SHALL be accepted (back-to-back throughput 2W+2 cycles).
REQ-022 ovf SHALL be set when an accumulate carries out of ACC_W bits, and SHALL hold until clr or reset; load mode SHALL NOT clear ovf.
REQ-023 clr in IDLE SHALL zero result and ovf on that edge.
REQ-024 clr while busy SHALL be ignored.
REQ-025 clr and start in the same IDLE cycle: clear first, then start; a mode-1 operation SHALL accumulate onto zero.
REQ-026 hex_out SHALL be combinational from result: nibble i (zero-padded above ACC_W) maps 0..F to C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E; bit 7 (decimal point) SHALL always be 1.

Reset
REQ-027 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, result=0, ovf=0, and clear internal product registers, including mid-operation.
REQ-028 rst_n=0 SHALL take priority over start and clr, with no completion pulse for an aborted operation.
REQ-029 hex_out SHALL read C0 on every digit after reset.

Verification (W=4, ACC_W=12, ND=3)
REQ-030 Load: a=3, b=5, c=2, d=7, acc_mode=0, start at edge k -> busy edges k+1..k+9; done only after edge k+9; result=0x01D; hex_out={F9? no: C0,F9,A1} (digit2..0); ovf=0.
REQ-031 Accumulate: after REQ-030, a=b=c=d=15, acc_mode=1 -> result=479 (0x1DF); hex_out digits {F9,A1,8E}.
REQ-032 Overflow: clr, then ten mode-1 operations of 15*15+15*15 -> result=404 (0x194) after the tenth; ovf=1 set at the tenth done and held through an eleventh load operation.
REQ-033 Ignored start: start held high for 20 cycles from idle -> exactly two operations, done pulses 10 cycles apart; operand change at edge k+3 has no effect.
REQ-034 Reset mid-operation: rst_n=0 at edge k+5 -> next cycle busy=0, result=0, ovf=0, no done pulse; a new start afterwards completes normally.
REQ-035 clr+start together in IDLE with result=0x1DF, mode 1, a=1, b=1, c=0, d=0 -> result=0x001, ovf=0.
